// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 8-by-4 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int unsigned DIV_A_W   = 8;
  localparam int unsigned DIV_B_W   = 4;
  localparam int unsigned DIV_ITERS = 8;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

  localparam logic [DIV_A_W-1:0] DIV0_QUOT = 8'hFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_B_W-1:0] r_i,
  input  logic               bit_i,
  input  logic [DIV_B_W-1:0] divisor_i,
  output logic [DIV_B_W-1:0] r_o,
  output logic               q_o
);

  logic [DIV_B_W:0] r5;

  always_comb begin
    r5  = {r_i, bit_i};
    q_o = (r5 >= {1'b0, divisor_i});
    // The difference is below the divisor whenever it is taken, so 4-bit wraparound is exact.
    r_o = q_o ? (r5[DIV_B_W-1:0] - divisor_i) : r5[DIV_B_W-1:0];
  end

endmodule

// File: rtl/div8x4.sv
// Sequential 8-bit by 4-bit unsigned restoring divider; one quotient bit per clock, MSB first.
module div8x4
  import div_pkg::*;
#(
  parameter int unsigned WIDTH_A = DIV_A_W,
  parameter int unsigned WIDTH_B = DIV_B_W
) (
  input  logic               clk,
  input  logic               reset_a_n,
  input  logic               start,
  input  logic [WIDTH_A-1:0] dividend,
  input  logic [WIDTH_B-1:0] divisor,
  output logic               done_flag,
  output logic               div0_flag,
  output logic [WIDTH_A-1:0] quotient_out,
  output logic [WIDTH_B-1:0] remainder_out
);

  localparam logic [DIV_CNT_W-1:0] LastIter = DIV_CNT_W'(DIV_ITERS - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
  logic [DIV_A_W-1:0]   shift_q, shift_d;
  logic [DIV_B_W-1:0]   r_q, r_d;
  logic [DIV_B_W-1:0]   dvsr_q, dvsr_d;
  logic [DIV_A_W-1:0]   quot_q, quot_d;
  logic [DIV_B_W-1:0]   rem_q, rem_d;
  logic                 done_q, done_d;
  logic                 div0_q, div0_d;

  logic [DIV_B_W-1:0]   step_r;
  logic                 step_q;

  div_step u_step (
    .r_i       (r_q),
    .bit_i     (shift_q[DIV_A_W-1]),
    .divisor_i (dvsr_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    r_d     = r_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = done_q;
    div0_d  = div0_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shift_d = dividend;
          dvsr_d  = divisor;
          r_d     = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          div0_d  = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = DIV0_QUOT;
            rem_d   = '0;
            div0_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        shift_d = {shift_q[DIV_A_W-2:0], step_q};
        r_d     = step_r;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = DONE;
          quot_d  = {shift_q[DIV_A_W-2:0], step_q};
          rem_d   = step_r;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      r_q     <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      r_q     <= r_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign done_flag     = done_q;
  assign div0_flag     = div0_q;
  assign quotient_out  = quot_q;
  assign remainder_out = rem_q;

endmodule

// File: tb/tb_div8x4.sv
// Directed plus random bench for div8x4 against plain integer division.
module tb_div8x4;

  logic       clk = 1'b0;
  logic       reset_a_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       done_flag;
  logic       div0_flag;
  logic [7:0] quotient_out;
  logic [3:0] remainder_out;

  int tests = 0;
  int fails = 0;
  int last_q = 0;
  int last_r = 0;

  always #5 clk = ~clk;

  div8x4 dut (
    .clk           (clk),
    .reset_a_n     (reset_a_n),
    .start         (start),
    .dividend      (dividend),
    .divisor       (divisor),
    .done_flag     (done_flag),
    .div0_flag     (div0_flag),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one division; optionally pulse a stray start (9 / 2) after inj_at iterations.
  task automatic run_op(input int a, input int b, input int inj_at, input string tag);
    int n;
    int eq;
    int er;
    int elat;
    if (b == 0) begin
      eq = 255; er = 0; elat = 0;
    end else begin
      eq = a / b; er = a % b; elat = 8;
    end
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 4'(b);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    if (b != 0) begin
      check({tag, " busy"}, 32'(done_flag), 0);
      check({tag, " old q held"}, 32'(quotient_out), last_q);
      check({tag, " old r held"}, 32'(remainder_out), last_r);
    end
    n = 0;
    while (!done_flag && n < 20) begin
      if (n == inj_at) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd2;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check({tag, " latency"}, n, elat);
    check({tag, " quotient"}, 32'(quotient_out), eq);
    check({tag, " remainder"}, 32'(remainder_out), er);
    check({tag, " div0"}, 32'(div0_flag), (b == 0) ? 1 : 0);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    reset_a_n = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("reset done", 32'(done_flag), 0);
    check("reset div0", 32'(div0_flag), 0);
    check("reset q", 32'(quotient_out), 0);
    check("reset r", 32'(remainder_out), 0);
    @(negedge clk);
    reset_a_n = 1'b1;

    run_op(200, 7, -1, "200/7");
    run_op(255, 1, -1, "255/1");
    run_op(5, 9, -1, "5/9");
    run_op(0, 15, -1, "0/15");
    run_op(255, 15, -1, "255/15");
    run_op(77, 0, -1, "77/0");
    run_op(100, 3, 4, "100/3 stray start");
    run_op(100, 3, -1, "100/3");
    run_op(50, 6, -1, "50/6 back-to-back");

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), -1, "random");
    end

    // Abort mid-operation with a non-zero result on display.
    run_op(200, 7, -1, "200/7 pre-abort");
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_a_n = 1'b0;
    #1;
    check("abort done", 32'(done_flag), 0);
    check("abort div0", 32'(div0_flag), 0);
    check("abort q", 32'(quotient_out), 0);
    check("abort r", 32'(remainder_out), 0);
    @(negedge clk);
    reset_a_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle hold done", 32'(done_flag), 0);
    check("idle hold q", 32'(quotient_out), 0);
    last_q = 0;
    last_r = 0;
    run_op(200, 7, -1, "200/7 after abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
